// File: rtl/br_pred_pkg.sv
// Shared helpers for the branch predictor table: counter geometry and the
// saturating / hysteresis next-state rule.
package br_pred_pkg;

  localparam int CTR_W_MAX = 4;

  typedef logic [CTR_W_MAX-1:0] ctr_raw_t;

  function automatic int idx_w(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  function automatic ctr_raw_t ctr_mid(input int w);
    return ctr_raw_t'(1 << (w - 1));
  endfunction

  function automatic ctr_raw_t ctr_max(input int w);
    return ctr_raw_t'((1 << w) - 1);
  endfunction

  // Hysteresis jumps straight across the taken/not-taken boundary from the
  // weak states; with CTR_W=1 the jump coincides with the plain step.
  function automatic ctr_raw_t sat_next(input ctr_raw_t c, input logic taken,
                                        input logic hyst, input int w);
    ctr_raw_t mx;
    ctr_raw_t mid;
    mx  = ctr_max(w);
    mid = ctr_mid(w);
    if (taken) begin
      if (hyst && (c == mid - 4'd1)) return mx;
      return (c == mx) ? c : c + 4'd1;
    end
    if (hyst && (c == mid)) return '0;
    return (c == '0) ? c : c - 4'd1;
  endfunction

endpackage

// File: rtl/br_sat_ctr.sv
// One CTR_W-bit prediction counter; resets to weakly not-taken.
module br_sat_ctr
  import br_pred_pkg::*;
#(
  parameter int CTR_W = 2,
  parameter int HYST  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd_en,
  input  logic             taken,
  output logic [CTR_W-1:0] ctr_o
);

  localparam logic [CTR_W-1:0] RST_VAL = CTR_W'(ctr_mid(CTR_W) - 4'd1);

  logic [CTR_W-1:0] ctr_q, ctr_d;
  ctr_raw_t         c_ext;

  always_comb begin
    c_ext              = '0;
    c_ext[CTR_W-1:0]   = ctr_q;
    ctr_d              = ctr_q;
    if (upd_en) ctr_d = CTR_W'(sat_next(c_ext, taken, HYST != 0, CTR_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctr_q <= RST_VAL;
    else        ctr_q <= ctr_d;
  end

  assign ctr_o = ctr_q;

endmodule

// File: rtl/br_pred_table.sv
// Table of saturating branch counters, bimodal or gshare-indexed, with a
// non-speculative history register and a saturating misprediction counter.
module br_pred_table
  import br_pred_pkg::*;
#(
  parameter  int ENTRIES = 64,
  parameter  int CTR_W   = 2,
  parameter  int PC_W    = 32,
  parameter  int GHR_W   = 0,
  parameter  int HYST    = 1,
  parameter  int STAT_W  = 16,
  localparam int IDX_W   = idx_w(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              brch_instr_detectd_IF,
  input  logic [PC_W-1:0]   pc_IF,
  output logic              predict_br_taken,
  output logic [IDX_W-1:0]  pred_idx_IF,
  input  logic              brch_instr_detectd_ID,
  input  logic              brch_hazard_stall,
  input  logic [IDX_W-1:0]  upd_idx_ID,
  input  logic              upd_pred_ID,
  input  logic              actual_brch_result,
  output logic [STAT_W-1:0] mispredict_cnt
);

  logic [CTR_W-1:0]  ctr_tbl [ENTRIES];
  logic [IDX_W-1:0]  ghr_ext;
  logic [IDX_W-1:0]  idx;
  logic              upd;
  logic [STAT_W-1:0] mcnt_q, mcnt_d;
  logic              unused_pc_bits;

  assign upd = brch_instr_detectd_ID & ~brch_hazard_stall;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    br_sat_ctr #(.CTR_W(CTR_W), .HYST(HYST)) u_ctr (
      .clk    (clk),
      .rst_n  (rst_n),
      .upd_en (upd && (upd_idx_ID == IDX_W'(i))),
      .taken  (actual_brch_result),
      .ctr_o  (ctr_tbl[i])
    );
  end

  // History only advances at resolution, so a same-cycle lookup sees the old value.
  if (GHR_W > 0) begin : g_ghr
    logic [GHR_W-1:0] ghr_q, ghr_d;

    always_comb begin
      ghr_d = ghr_q;
      if (upd) ghr_d = (ghr_q << 1) | GHR_W'(actual_brch_result);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ghr_q <= '0;
      else        ghr_q <= ghr_d;
    end

    assign ghr_ext = IDX_W'(ghr_q);
  end else begin : g_bimodal
    assign ghr_ext = '0;
  end

  assign idx              = pc_IF[IDX_W+1:2] ^ ghr_ext;
  assign pred_idx_IF      = idx;
  assign predict_br_taken = brch_instr_detectd_IF & ctr_tbl[idx][CTR_W-1];
  assign unused_pc_bits   = ^{pc_IF[PC_W-1:IDX_W+2], pc_IF[1:0]};

  always_comb begin
    mcnt_d = mcnt_q;
    if (upd && (upd_pred_ID != actual_brch_result) && (mcnt_q != '1))
      mcnt_d = mcnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcnt_q <= '0;
    else        mcnt_q <= mcnt_d;
  end

  assign mispredict_cnt = mcnt_q;

endmodule

// File: tb/tb_br_pred_table.sv
// Bench for br_pred_table: a legacy 2-bit hysteresis bimodal table and a
// 3-bit plain-saturating gshare table driven from the same stimulus.
module tb_br_pred_table;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_if;
  logic [31:0] pc_if;
  logic        br_id;
  logic        stall;
  logic [5:0]  upd_idx;
  logic        upd_pred;
  logic        actual;

  logic        pred_a, pred_b;
  logic [5:0]  pidx_a, pidx_b;
  logic [3:0]  mcnt_a;
  logic [15:0] mcnt_b;

  always #5 clk = ~clk;

  br_pred_table #(.ENTRIES(64), .CTR_W(2), .PC_W(32), .GHR_W(0), .HYST(1), .STAT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .brch_instr_detectd_IF(br_if), .pc_IF(pc_if),
    .predict_br_taken(pred_a), .pred_idx_IF(pidx_a), .brch_instr_detectd_ID(br_id),
    .brch_hazard_stall(stall), .upd_idx_ID(upd_idx), .upd_pred_ID(upd_pred),
    .actual_brch_result(actual), .mispredict_cnt(mcnt_a)
  );

  br_pred_table #(.ENTRIES(64), .CTR_W(3), .PC_W(32), .GHR_W(4), .HYST(0), .STAT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .brch_instr_detectd_IF(br_if), .pc_IF(pc_if),
    .predict_br_taken(pred_b), .pred_idx_IF(pidx_b), .brch_instr_detectd_ID(br_id),
    .brch_hazard_stall(stall), .upd_idx_ID(upd_idx), .upd_pred_ID(upd_pred),
    .actual_brch_result(actual), .mispredict_cnt(mcnt_b)
  );

  typedef struct {
    logic       br_if;
    logic [5:0] pcidx;
    logic       br_id;
    logic       stall;
    logic [5:0] uidx;
    logic       act;
    logic       pa;
    logic       pb;
    logic [5:0] ib;
  } vec_t;

  typedef struct {
    logic       pa;
    logic [5:0] ia;
    logic       pb;
    logic [5:0] ib;
    logic [3:0] ma;
    logic [15:0] mb;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  int         m_a [64];
  int         m_b [64];
  logic [3:0] m_ghr;
  int         m_cnt_a, m_cnt_b;

  task automatic check(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act_v, exp_v);
    end
  endtask

  function automatic vec_t mk(input logic bi, input int pci, input logic bd, input logic st,
                              input int ui, input logic ac, input logic pa, input logic pb,
                              input int ib);
    vec_t v;
    v.br_if = bi; v.pcidx = 6'(pci); v.br_id = bd; v.stall = st;
    v.uidx = 6'(ui); v.act = ac; v.pa = pa; v.pb = pb; v.ib = 6'(ib);
    return v;
  endfunction

  // Independent reference for one counter step.
  function automatic int nxt(input int c, input bit t, input bit h, input int w);
    int mx, md;
    mx = (1 << w) - 1;
    md = 1 << (w - 1);
    if (t) return (h && c == md - 1) ? mx : ((c < mx) ? c + 1 : mx);
    return (h && c == md) ? 0 : ((c > 0) ? c - 1 : 0);
  endfunction

  task automatic idle_inputs();
    br_if = 1'b0; pc_if = '0; br_id = 1'b0; stall = 1'b0;
    upd_idx = '0; upd_pred = 1'b0; actual = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_a[i] = 1;
      m_b[i] = 3;
    end
    m_ghr = '0; m_cnt_a = 0; m_cnt_b = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic compare_now(input string tag);
    exp_t e;
    @(negedge clk);
    if (sbq.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s.scoreboard: got empty queue, expected an entry", tag);
    end else begin
      e = sbq.pop_front();
      check({tag, ".pred_a"}, 32'(pred_a), 32'(e.pa));
      check({tag, ".idx_a"},  32'(pidx_a), 32'(e.ia));
      check({tag, ".pred_b"}, 32'(pred_b), 32'(e.pb));
      check({tag, ".idx_b"},  32'(pidx_b), 32'(e.ib));
      check({tag, ".mcnt_a"}, 32'(mcnt_a), 32'(e.ma));
      check({tag, ".mcnt_b"}, 32'(mcnt_b), 32'(e.mb));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [20];
    exp_t e;
    int   pcidx;

    // Reset state, checked while reset is held and before any clock edge.
    idle_inputs();
    rst_n = 1'b0;
    br_if = 1'b1; pc_if = 32'h100;
    #3;
    check("rst.pred_a", 32'(pred_a), 32'h0);
    check("rst.idx_a",  32'(pidx_a), 32'h00);
    check("rst.pred_b", 32'(pred_b), 32'h0);
    check("rst.mcnt_a", 32'(mcnt_a), 32'h0);
    check("rst.mcnt_b", 32'(mcnt_b), 32'h0);
    br_if = 1'b0;
    #1;
    check("rst.pred_a_if0", 32'(pred_a), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    //          if pcidx id st ui ac  pa pb ib
    tbl[0]  = mk(1, 5,  0, 0, 0, 0,  0, 0, 5);
    tbl[1]  = mk(1, 5,  1, 0, 5, 1,  0, 0, 5);
    tbl[2]  = mk(1, 5,  1, 0, 5, 1,  1, 0, 4);
    tbl[3]  = mk(1, 5,  1, 0, 5, 0,  1, 0, 6);
    tbl[4]  = mk(1, 5,  1, 0, 5, 0,  1, 0, 3);
    tbl[5]  = mk(1, 5,  0, 0, 0, 0,  0, 0, 9);
    tbl[6]  = mk(1, 14, 1, 0, 2, 1,  0, 0, 2);
    tbl[7]  = mk(1, 11, 1, 0, 2, 1,  0, 1, 2);
    tbl[8]  = mk(1, 1,  1, 0, 2, 1,  0, 1, 2);
    tbl[9]  = mk(1, 5,  1, 0, 2, 1,  0, 1, 2);
    tbl[10] = mk(1, 13, 1, 0, 2, 1,  0, 1, 2);
    tbl[11] = mk(1, 13, 1, 0, 2, 0,  0, 1, 2);
    tbl[12] = mk(1, 12, 0, 0, 0, 0,  0, 1, 2);
    tbl[13] = mk(1, 2,  0, 0, 0, 0,  1, 0, 12);
    tbl[14] = mk(1, 7,  1, 1, 7, 1,  0, 0, 9);
    tbl[15] = mk(1, 7,  0, 0, 0, 0,  0, 0, 9);
    tbl[16] = mk(1, 7,  1, 0, 7, 1,  0, 0, 9);
    tbl[17] = mk(1, 7,  0, 0, 0, 0,  1, 0, 10);
    tbl[18] = mk(0, 7,  0, 0, 0, 0,  0, 0, 10);
    tbl[19] = mk(1, 10, 0, 0, 0, 0,  0, 1, 7);

    for (int i = 0; i < 20; i++) begin
      br_if    = tbl[i].br_if;
      pc_if    = 32'h0000_1000 | {24'h0, tbl[i].pcidx, 2'b00};
      br_id    = tbl[i].br_id;
      stall    = tbl[i].stall;
      upd_idx  = tbl[i].uidx;
      actual   = tbl[i].act;
      upd_pred = tbl[i].act;
      e.pa = tbl[i].pa; e.ia = tbl[i].pcidx; e.pb = tbl[i].pb; e.ib = tbl[i].ib;
      e.ma = 4'h0; e.mb = 16'h0;
      sbq.push_back(e);
      compare_now($sformatf("vec%0d", i));
      @(posedge clk); #1;
    end

    // History T,T,N,T then a gshare lookup at pc 0x40.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      br_id = 1'b1; upd_idx = 6'd20;
      actual = (i != 2); upd_pred = (i != 2);
      @(posedge clk); #1;
    end
    idle_inputs();
    br_if = 1'b1; pc_if = 32'h40;
    #1;
    check("ghr.idx_b", 32'(pidx_b), 32'h1D);
    check("ghr.idx_a", 32'(pidx_a), 32'h10);

    // Misprediction burst: 4-bit stat saturates, 16-bit one keeps counting.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      br_id = 1'b1; upd_idx = 6'd30; upd_pred = 1'b0; actual = 1'b1;
      @(posedge clk); #1;
      if (i == 13) check("stat.mcnt_a_14", 32'(mcnt_a), 32'd14);
    end
    check("stat.mcnt_a_sat", 32'(mcnt_a), 32'd15);
    check("stat.mcnt_b",     32'(mcnt_b), 32'd20);
    br_if = 1'b1; pc_if = {24'h0, 6'd30, 2'b00};
    @(posedge clk); #1;
    check("stat.pred_a_pre", 32'(pred_a), 32'h1);
    check("stat.mcnt_b_21",  32'(mcnt_b), 32'd21);
    #1 rst_n = 1'b0;
    #1;
    check("midrst.mcnt_a", 32'(mcnt_a), 32'd0);
    check("midrst.mcnt_b", 32'(mcnt_b), 32'd0);
    check("midrst.pred_a", 32'(pred_a), 32'h0);
    check("midrst.idx_a",  32'(pidx_a), 32'd30);
    do_reset();

    // Randomised traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      pcidx    = $urandom_range(0, 15);
      br_if    = 1'($urandom_range(0, 1));
      pc_if    = ($urandom() & 32'hFFFF_FF03) | 32'(pcidx << 2);
      br_id    = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      upd_idx  = 6'($urandom_range(0, 15));
      upd_pred = 1'($urandom_range(0, 1));
      actual   = 1'($urandom_range(0, 1));
      e.ia = pc_if[7:2];
      e.ib = pc_if[7:2] ^ {2'b00, m_ghr};
      e.pa = br_if & m_a[e.ia][1];
      e.pb = br_if & m_b[e.ib][2];
      e.ma = 4'(m_cnt_a);
      e.mb = 16'(m_cnt_b);
      sbq.push_back(e);
      compare_now("rnd");
      if (br_id && !stall) begin
        m_a[upd_idx] = nxt(m_a[upd_idx], actual, 1'b1, 2);
        m_b[upd_idx] = nxt(m_b[upd_idx], actual, 1'b0, 3);
        m_ghr = {m_ghr[2:0], actual};
        if (upd_pred != actual) begin
          if (m_cnt_a < 15) m_cnt_a++;
          m_cnt_b++;
        end
      end
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
